exit_status_uart_reporter: RTL and testbench

- Sits downstream of the x_heep_system FPGA top level, in the same clk_gen domain.
- Consumes the system's exit_valid/exit_value (32-bit) pair.
- On completion of a program, transmits a fixed-format ASCII status line on a dedicated debug UART TX pin, so board runs can be scored from a host terminal without JTAG.
- Pure transmitter: 8N1 framing, parameterised bit period.

---
 rtl/exit_status_uart_reporter.sv | 176 +++++++++++++++++
 tb/tb_exit_status_uart_reporter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/exit_status_uart_reporter.sv
// Sends "EXIT 0xHHHHHHHH\r\n" over an 8N1 debug UART when exit_valid_i rises.
// Define EXIT_REPORT_PASS_FAIL_EN to add pass_o and a " PASS"/" FAIL" suffix.
module exit_status_uart_reporter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o
`ifdef EXIT_REPORT_PASS_FAIL_EN
  ,
  output logic        pass_o
`endif
);

`ifdef EXIT_REPORT_PASS_FAIL_EN
  localparam int NBYTES = 22;
`else
  localparam int NBYTES = 17;
`endif
  localparam logic [4:0]  LAST_IDX = 5'(NBYTES - 1);
  localparam logic [15:0] CNT_MAX  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic        exit_valid_prev_q;
  logic [31:0] shadow_q, shadow_d;
  logic [4:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic        done;
  logic        rise;
  logic [2:0]  nib_pos;
  logic [4:0]  nib_shift;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  tx_byte;
`ifdef EXIT_REPORT_PASS_FAIL_EN
  logic        pass_q, pass_d;
`endif

  assign rise = exit_valid_i & ~exit_valid_prev_q;

  // Digits occupy byte indices 7..14, MSB nibble first.
  always_comb begin
    nib_pos   = 3'(byte_idx_q - 5'd7);
    nib_shift = {3'd7 - nib_pos, 2'b00};
    nibble    = 4'(shadow_q >> nib_shift);
    hex_char  = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    case (byte_idx_q)
      5'd0:    tx_byte = 8'h45;
      5'd1:    tx_byte = 8'h58;
      5'd2:    tx_byte = 8'h49;
      5'd3:    tx_byte = 8'h54;
      5'd4:    tx_byte = 8'h20;
      5'd5:    tx_byte = 8'h30;
      5'd6:    tx_byte = 8'h78;
      5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14:
               tx_byte = hex_char;
`ifdef EXIT_REPORT_PASS_FAIL_EN
      5'd15:   tx_byte = 8'h20;
      5'd16:   tx_byte = pass_q ? 8'h50 : 8'h46;
      5'd17:   tx_byte = 8'h41;
      5'd18:   tx_byte = pass_q ? 8'h53 : 8'h49;
      5'd19:   tx_byte = pass_q ? 8'h53 : 8'h4C;
      5'd20:   tx_byte = 8'h0D;
`else
      5'd15:   tx_byte = 8'h0D;
`endif
      default: tx_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    clk_cnt_d  = clk_cnt_q;
    done       = 1'b0;
`ifdef EXIT_REPORT_PASS_FAIL_EN
    pass_d     = pass_q;
`endif
    case (state_q)
      IDLE: begin
        clk_cnt_d = 16'd0;
        if (rise) begin
          shadow_d   = exit_value_i;
          byte_idx_d = 5'd0;
          state_d    = START;
`ifdef EXIT_REPORT_PASS_FAIL_EN
          pass_d     = (exit_value_i == 32'd0);
`endif
        end
      end
      START: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = 16'd0;
          if (byte_idx_q == LAST_IDX) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 5'd1;
            state_d    = START;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      exit_valid_prev_q <= 1'b0;
      shadow_q          <= 32'd0;
      byte_idx_q        <= 5'd0;
      bit_idx_q         <= 3'd0;
      clk_cnt_q         <= 16'd0;
`ifdef EXIT_REPORT_PASS_FAIL_EN
      pass_q            <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      exit_valid_prev_q <= exit_valid_i;
      shadow_q          <= shadow_d;
      byte_idx_q        <= byte_idx_d;
      bit_idx_q         <= bit_idx_d;
      clk_cnt_q         <= clk_cnt_d;
`ifdef EXIT_REPORT_PASS_FAIL_EN
      pass_q            <= pass_d;
`endif
    end
  end

  // tx and busy decode straight from the state flop, so reset forces idle-high at once.
  always_comb begin
    case (state_q)
      START:   uart_tx_o = 1'b0;
      DATA:    uart_tx_o = tx_byte[bit_idx_q];
      default: uart_tx_o = 1'b1;
    endcase
  end

  // done marks the final stop-bit cycle; busy drops in that same cycle.
  assign done_o = done;
  assign busy_o = (state_q != IDLE) & ~done;
`ifdef EXIT_REPORT_PASS_FAIL_EN
  assign pass_o = pass_q;
`endif

endmodule

// File: tb/tb_exit_status_uart_reporter.sv
// Directed bench for exit_status_uart_reporter with CLKS_PER_BIT=4; decodes the
// serial line bit by bit and compares against hand-written expected text.
module tb_exit_status_uart_reporter;

  localparam int CPB = 4;
`ifdef EXIT_REPORT_PASS_FAIL_EN
  localparam int NBYTES = 22;
`else
  localparam int NBYTES = 17;
`endif

  logic        clk_gen;
  logic        rst_n;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;
`ifdef EXIT_REPORT_PASS_FAIL_EN
  logic        pass_o;
`endif

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  exit_status_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk_gen      (clk_gen),
    .rst_n        (rst_n),
    .exit_valid_i (exit_valid_i),
    .exit_value_i (exit_value_i),
    .uart_tx_o    (uart_tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef EXIT_REPORT_PASS_FAIL_EN
    ,
    .pass_o       (pass_o)
`endif
  );

  // clock / reset
  initial clk_gen = 1'b0;
  always #5 clk_gen = ~clk_gen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard: push the expected line, including suffix and CR LF
  task automatic push_msg(input string s, input bit pass);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
`ifdef EXIT_REPORT_PASS_FAIL_EN
    begin
      string sfx;
      sfx = pass ? " PASS" : " FAIL";
      for (int i = 0; i < sfx.len(); i++) exp_q.push_back(8'(sfx[i]));
    end
`else
    if (pass) begin end
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // driver tasks
  task automatic drop_valid();
    @(negedge clk_gen);
    exit_valid_i = 1'b0;
    @(negedge clk_gen);
  endtask

  task automatic start_msg(input logic [31:0] value);
    @(negedge clk_gen);
    exit_value_i = value;
    exit_valid_i = 1'b1;
    @(posedge clk_gen);
    #1;
    check("start_tx", {31'd0, uart_tx_o}, 32'd0);
    check("start_busy", {31'd0, busy_o}, 32'd1);
  endtask

  // Entered 1 time unit after the edge that began the start bit.
  task automatic recv_msg();
    int done_cnt;
    int done_last;
    int busy_bad;
    done_cnt  = 0;
    done_last = 0;
    busy_bad  = 0;
    for (int b = 0; b < NBYTES; b++) begin
      logic [9:0] bits;
      logic       stable;
      logic [7:0] exp_b;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
        for (int o = 0; o < CPB; o++) begin
          bit is_last;
          is_last = (b == NBYTES - 1) && (k == 9) && (o == CPB - 1);
          if (o == 0) bits[k] = uart_tx_o;
          else if (uart_tx_o !== bits[k]) stable = 1'b0;
          if (done_o === 1'b1) done_cnt++;
          if (is_last && done_o === 1'b1) done_last = 1;
          if (busy_o !== !is_last) busy_bad++;
          @(posedge clk_gen);
          #1;
        end
      end
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
      check($sformatf("start_bit[%0d]", b), {31'd0, bits[0]}, 32'd0);
      check($sformatf("data[%0d]", b), {24'd0, bits[8:1]}, {24'd0, exp_b});
      check($sformatf("stop_bit[%0d]", b), {31'd0, bits[9]}, 32'd1);
      check($sformatf("bit_width[%0d]", b), {31'd0, stable}, 32'd1);
    end
    check("done_pulses", done_cnt, 1);
    check("done_at_last", done_last, 1);
    check("busy_during", busy_bad, 0);
    check("post_tx", {31'd0, uart_tx_o}, 32'd1);
    check("post_busy", {31'd0, busy_o}, 32'd0);
    check("post_done", {31'd0, done_o}, 32'd0);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  task automatic idle_watch(input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_gen);
      #1;
      if (uart_tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = 32'd0;
    repeat (3) @(posedge clk_gen);
    #1;
    check("rst_tx", {31'd0, uart_tx_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
`ifdef EXIT_REPORT_PASS_FAIL_EN
    check("rst_pass", {31'd0, pass_o}, 32'd0);
`endif
    @(negedge clk_gen);
    rst_n = 1'b1;
    idle_watch(1000, "idle_no_trigger");

    // all-zero value
    push_msg("EXIT 0x00000000", 1'b1);
    start_msg(32'h0000_0000);
    recv_msg();
`ifdef EXIT_REPORT_PASS_FAIL_EN
    check("pass_zero", {31'd0, pass_o}, 32'd1);
`endif

    // DEADBEEF
    drop_valid();
    push_msg("EXIT 0xDEADBEEF", 1'b0);
    start_msg(32'hDEAD_BEEF);
    recv_msg();
`ifdef EXIT_REPORT_PASS_FAIL_EN
    check("pass_deadbeef", {31'd0, pass_o}, 32'd0);
`endif

    // re-trigger and value change mid-message must not disturb it
    drop_valid();
    push_msg("EXIT 0x12345678", 1'b0);
    start_msg(32'h1234_5678);
    fork
      recv_msg();
      begin
        repeat (100) @(negedge clk_gen);
        exit_valid_i = 1'b0;
        repeat (20) @(negedge clk_gen);
        exit_valid_i = 1'b1;
        exit_value_i = 32'h0000_0001;
      end
    join
    idle_watch(60, "no_second_msg");

    drop_valid();
    push_msg("EXIT 0x00000001", 1'b0);
    start_msg(32'h0000_0001);
    recv_msg();

    // reset during DATA of byte 5, valid held high across release
    drop_valid();
    start_msg(32'h9A0F_F09A);
    repeat (5 * 10 * CPB + CPB + 6) @(posedge clk_gen);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, uart_tx_o}, 32'd1);
    check("async_rst_busy", {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk_gen);
    rst_n = 1'b1;
    push_msg("EXIT 0x9A0FF09A", 1'b0);
    @(posedge clk_gen);
    #1;
    check("rerun_tx", {31'd0, uart_tx_o}, 32'd0);
    check("rerun_busy", {31'd0, busy_o}, 32'd1);
    recv_msg();
`ifdef EXIT_REPORT_PASS_FAIL_EN
    check("pass_9a0f", {31'd0, pass_o}, 32'd0);
`endif
    idle_watch(20, "final_idle");

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
